// File: rtl/scarv_cop_palu_issue.sv
// Issue/writeback stage in front of the packed ALU: latches one instruction, holds it on the PALU until done, writes the CPR, reports completion.
// Latency: accept edge T -> EXEC -> WB write -> rsp_valid; a combinational PALU op gives the next accept at T+4 at the earliest.
// Backpressure: insn_ready is high only in IDLE; rsp_valid and its fields are held until rsp_ready, and a watchdog aborts a stuck EXEC.
module scarv_cop_palu_issue #(
  parameter int TIMEOUT = 64  // EXEC cycles allowed without palu_idone, 2..255
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        insn_valid,
  output logic        insn_ready,
  input  logic [31:0] insn_gpr_rs1,
  input  logic [31:0] insn_rs1,
  input  logic [31:0] insn_rs2,
  input  logic [31:0] insn_rs3,
  input  logic [31:0] insn_imm,
  input  logic [2:0]  insn_pw,
  input  logic [3:0]  insn_class,
  input  logic [4:0]  insn_subclass,
  input  logic [3:0]  insn_rd,
  output logic        palu_ivalid,
  input  logic        palu_idone,
  output logic [31:0] gpr_rs1,
  output logic [31:0] palu_rs1,
  output logic [31:0] palu_rs2,
  output logic [31:0] palu_rs3,
  output logic [31:0] id_imm,
  output logic [2:0]  id_pw,
  output logic [3:0]  id_class,
  output logic [4:0]  id_subclass,
  input  logic [3:0]  palu_cpr_rd_ben,
  input  logic [31:0] palu_cpr_rd_wdata,
  output logic [3:0]  cpr_wen,
  output logic [3:0]  cpr_waddr,
  output logic [31:0] cpr_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [3:0]  rsp_rd,
  output logic        rsp_wrote,
  output logic        rsp_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2,
    S_RESP = 2'd3
  } state_t;

  // Watchdog fires on the last allowed EXEC cycle, counting from 0.
  localparam logic [7:0] LAST_CYCLE = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] cycle_cnt;
  logic [3:0] rd_q;

  // Single FSM; every output is a register so nothing glitches into the PALU or CPR file.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state       <= S_IDLE;
      cycle_cnt   <= 8'd0;
      rd_q        <= 4'd0;
      insn_ready  <= 1'b0;
      palu_ivalid <= 1'b0;
      gpr_rs1     <= 32'd0;
      palu_rs1    <= 32'd0;
      palu_rs2    <= 32'd0;
      palu_rs3    <= 32'd0;
      id_imm      <= 32'd0;
      id_pw       <= 3'd0;
      id_class    <= 4'd0;
      id_subclass <= 5'd0;
      cpr_wen     <= 4'd0;
      cpr_waddr   <= 4'd0;
      cpr_wdata   <= 32'd0;
      rsp_valid   <= 1'b0;
      rsp_rd      <= 4'd0;
      rsp_wrote   <= 1'b0;
      rsp_err     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // insn_ready rises one cycle after reset release, then stays up while idle.
          insn_ready <= 1'b1;
          if (insn_valid && insn_ready) begin
            gpr_rs1     <= insn_gpr_rs1;
            palu_rs1    <= insn_rs1;
            palu_rs2    <= insn_rs2;
            palu_rs3    <= insn_rs3;
            id_imm      <= insn_imm;
            id_pw       <= insn_pw;
            id_class    <= insn_class;
            id_subclass <= insn_subclass;
            rd_q        <= insn_rd;
            cycle_cnt   <= 8'd0;
            insn_ready  <= 1'b0;
            palu_ivalid <= 1'b1;
            state       <= S_EXEC;
          end
        end

        S_EXEC: begin
          // Completion is checked first so a done on the watchdog cycle still writes back.
          if (palu_idone) begin
            palu_ivalid <= 1'b0;
            cpr_wen     <= palu_cpr_rd_ben;
            cpr_waddr   <= rd_q;
            cpr_wdata   <= palu_cpr_rd_wdata;
            state       <= S_WB;
          end else if (cycle_cnt == LAST_CYCLE) begin
            palu_ivalid <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rd      <= rd_q;
            rsp_wrote   <= 1'b0;
            rsp_err     <= 1'b1;
            state       <= S_RESP;
          end else begin
            cycle_cnt <= cycle_cnt + 8'd1;
          end
        end

        S_WB: begin
          // The write lasts exactly this one cycle; a zero byte mask still reports completion.
          cpr_wen   <= 4'd0;
          cpr_waddr <= 4'd0;
          cpr_wdata <= 32'd0;
          rsp_valid <= 1'b1;
          rsp_rd    <= rd_q;
          rsp_wrote <= |cpr_wen;
          rsp_err   <= 1'b0;
          state     <= S_RESP;
        end

        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid  <= 1'b0;
            rsp_rd     <= 4'd0;
            rsp_wrote  <= 1'b0;
            rsp_err    <= 1'b0;
            insn_ready <= 1'b1;
            state      <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scarv_cop_palu_issue.sv
// Bench for scarv_cop_palu_issue: directed instructions, a stub PALU, and a queue-based scoreboard.
// Expected CPR writes and responses (with latency from the accept edge) are queued at issue time.
// A negedge monitor pops and compares whenever the DUT writes the CPR file or raises rsp_valid.
module tb_scarv_cop_palu_issue;

  logic        g_clk = 1'b0;
  logic        g_reset = 1'b1;
  logic        insn_valid = 1'b0;
  logic        insn_ready;
  logic [31:0] insn_gpr_rs1 = '0, insn_rs1 = '0, insn_rs2 = '0, insn_rs3 = '0, insn_imm = '0;
  logic [2:0]  insn_pw = '0;
  logic [3:0]  insn_class = '0;
  logic [4:0]  insn_subclass = '0;
  logic [3:0]  insn_rd = '0;
  logic        palu_ivalid;
  logic        palu_idone = 1'b0;
  logic [31:0] gpr_rs1, palu_rs1, palu_rs2, palu_rs3, id_imm;
  logic [2:0]  id_pw;
  logic [3:0]  id_class;
  logic [4:0]  id_subclass;
  logic [3:0]  palu_cpr_rd_ben = '0;
  logic [31:0] palu_cpr_rd_wdata = '0;
  logic [3:0]  cpr_wen, cpr_waddr;
  logic [31:0] cpr_wdata;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [3:0]  rsp_rd;
  logic        rsp_wrote, rsp_err;

  scarv_cop_palu_issue #(.TIMEOUT(64)) dut (
    .g_clk(g_clk), .g_reset(g_reset),
    .insn_valid(insn_valid), .insn_ready(insn_ready),
    .insn_gpr_rs1(insn_gpr_rs1), .insn_rs1(insn_rs1), .insn_rs2(insn_rs2), .insn_rs3(insn_rs3),
    .insn_imm(insn_imm), .insn_pw(insn_pw), .insn_class(insn_class), .insn_subclass(insn_subclass),
    .insn_rd(insn_rd),
    .palu_ivalid(palu_ivalid), .palu_idone(palu_idone),
    .gpr_rs1(gpr_rs1), .palu_rs1(palu_rs1), .palu_rs2(palu_rs2), .palu_rs3(palu_rs3),
    .id_imm(id_imm), .id_pw(id_pw), .id_class(id_class), .id_subclass(id_subclass),
    .palu_cpr_rd_ben(palu_cpr_rd_ben), .palu_cpr_rd_wdata(palu_cpr_rd_wdata),
    .cpr_wen(cpr_wen), .cpr_waddr(cpr_waddr), .cpr_wdata(cpr_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rd(rsp_rd), .rsp_wrote(rsp_wrote), .rsp_err(rsp_err)
  );

  always #5 g_clk = ~g_clk;

  // Rising-edge count; an accept on edge A makes cyc == A at the following negedge.
  int cyc = 0;
  always @(posedge g_clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    end
  endtask

  typedef struct {
    logic [3:0] rd;
    logic       wrote;
    logic       err;
    int         lat;
  } rsp_t;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  ben;
    int          lat;
  } wr_t;

  rsp_t rq[$];
  wr_t  wq[$];
  rsp_t r_exp;
  wr_t  w_exp;

  // Values the current instruction should present to the PALU, and how the stub PALU answers.
  logic [31:0] cur_gpr = '0, cur_rs1 = '0, cur_rs2 = '0, cur_rs3 = '0, cur_imm = '0;
  logic [2:0]  cur_pw = '0;
  logic [3:0]  cur_cls = '0;
  logic [4:0]  cur_sub = '0;
  int          pl_delay = 1;
  logic [3:0]  pl_ben = '0;
  logic [31:0] pl_wdata = '0;
  int          acc_cyc = 0;
  int          prev_acc = 0;

  // Stub PALU: raises idone in its pl_delay-th EXEC cycle (never when 0) and checks operand stability.
  int ex_cnt = 0;
  always @(negedge g_clk) begin
    if (palu_ivalid && !g_reset) begin
      ex_cnt++;
      chk("palu_operands_stable",
          {gpr_rs1, palu_rs1, palu_rs2, palu_rs3, id_imm, id_pw, id_class, id_subclass},
          {cur_gpr, cur_rs1, cur_rs2, cur_rs3, cur_imm, cur_pw, cur_cls, cur_sub});
      palu_idone = (pl_delay != 0) && (ex_cnt == pl_delay);
    end else begin
      ex_cnt = 0;
      palu_idone = 1'b0;
    end
    palu_cpr_rd_ben   = palu_idone ? pl_ben   : 4'hA;
    palu_cpr_rd_wdata = palu_idone ? pl_wdata : 32'hDEAD_BEEF;
  end

  // Monitor: pops expectations on CPR writes and on rising rsp_valid; checks hold and return to IDLE.
  logic       prev_v = 1'b0;
  logic [5:0] prev_f = '0;
  always @(negedge g_clk) begin
    if (g_reset) begin
      prev_v = 1'b0;
    end else begin
      if (cpr_wen != 4'd0) begin
        if (wq.size() == 0) begin
          chk("unexpected_cpr_write", {cpr_wen, cpr_waddr, cpr_wdata}, '0);
        end else begin
          w_exp = wq.pop_front();
          chk("cpr_write", {cpr_wen, cpr_waddr, cpr_wdata, 32'(cyc - acc_cyc)},
              {w_exp.ben, w_exp.addr, w_exp.data, 32'(w_exp.lat)});
        end
      end
      if (rsp_valid) begin
        chk("insn_ready_low_in_resp", insn_ready, 1'b0);
        if (!prev_v) begin
          if (rq.size() == 0) begin
            chk("unexpected_rsp", {rsp_rd, rsp_wrote, rsp_err}, '0);
          end else begin
            r_exp = rq.pop_front();
            chk("rsp_fields", {rsp_rd, rsp_wrote, rsp_err, 32'(cyc - acc_cyc)},
                {r_exp.rd, r_exp.wrote, r_exp.err, 32'(r_exp.lat)});
          end
        end else begin
          chk("rsp_held_stable", {rsp_rd, rsp_wrote, rsp_err}, prev_f);
        end
      end else if (prev_v) begin
        chk("idle_after_rsp", insn_ready, 1'b1);
      end
      prev_v = rsp_valid;
      prev_f = {rsp_rd, rsp_wrote, rsp_err};
    end
  end

  task automatic issue(input logic [31:0] gpr, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] rs3, input logic [31:0] imm, input logic [2:0] pw,
                       input logic [3:0] cls, input logic [4:0] sub, input logic [3:0] rd,
                       input int delay, input logic [3:0] ben, input logic [31:0] wdata,
                       input bit expect_done, input int wlat, input int rlat, input bit err);
    int t;
    @(negedge g_clk);
    insn_gpr_rs1 = gpr; insn_rs1 = rs1; insn_rs2 = rs2; insn_rs3 = rs3; insn_imm = imm;
    insn_pw = pw; insn_class = cls; insn_subclass = sub; insn_rd = rd;
    cur_gpr = gpr; cur_rs1 = rs1; cur_rs2 = rs2; cur_rs3 = rs3; cur_imm = imm;
    cur_pw = pw; cur_cls = cls; cur_sub = sub;
    pl_delay = delay; pl_ben = ben; pl_wdata = wdata;
    insn_valid = 1'b1;
    t = 0;
    while (!insn_ready && t < 200) begin
      @(negedge g_clk);
      t++;
    end
    chk("insn_accept", insn_ready, 1'b1);
    prev_acc = acc_cyc;
    acc_cyc = cyc + 1;
    if (expect_done) begin
      if (ben != 4'd0 && !err) wq.push_back('{addr: rd, data: wdata, ben: ben, lat: wlat});
      rq.push_back('{rd: rd, wrote: (ben != 4'd0) && !err, err: err, lat: rlat});
    end
    @(negedge g_clk);
    // Scramble the inputs so only the latched copies can keep the PALU operands stable.
    insn_valid = 1'b0;
    insn_gpr_rs1 = $urandom; insn_rs1 = $urandom; insn_rs2 = $urandom; insn_rs3 = $urandom;
    insn_imm = $urandom; insn_pw = 3'($urandom); insn_class = 4'($urandom);
    insn_subclass = 5'($urandom); insn_rd = 4'($urandom);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while ((rq.size() != 0 || rsp_valid || palu_ivalid) && t < 400) begin
      @(negedge g_clk);
      t++;
    end
    chk("rsp_queue_drained", rq.size(), 0);
    chk("wr_queue_drained", wq.size(), 0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk(nm, {insn_ready, palu_ivalid, gpr_rs1, palu_rs1, palu_rs2, palu_rs3, id_imm, id_pw,
             id_class, id_subclass, cpr_wen, cpr_waddr, cpr_wdata, rsp_valid, rsp_rd,
             rsp_wrote, rsp_err}, '0);
  endtask

  initial begin
    int t;
    // Reset state
    repeat (3) @(negedge g_clk);
    chk_all_zero("reset_outputs");
    g_reset = 1'b0;
    @(negedge g_clk);
    @(negedge g_clk);
    chk("insn_ready_after_reset", insn_ready, 1'b1);

    // 1. PADD word 3+5 -> rd 2, then 2. CMOV_F (false, ben 0) back-to-back.
    issue(32'h0, 32'd3, 32'd5, 32'h0, 32'h0, 3'd1, 4'h1, 5'h01, 4'd2,
          1, 4'hF, 32'd8, 1'b1, 1, 2, 1'b0);
    issue(32'h0, 32'h1234_5678, 32'd1, 32'hAAAA_5555, 32'h0, 3'd1, 4'h1, 5'h10, 4'd5,
          1, 4'h0, 32'h1234_5678, 1'b1, 1, 2, 1'b0);
    chk("b2b_accept_gap", 32'(acc_cyc - prev_acc), 32'd4);
    wait_done();

    // 3. PMUL_L halfwords {3,2}*{5,4} -> {15,8}, PALU done in its 8th EXEC cycle.
    issue(32'hCAFE_0001, 32'h0003_0002, 32'h0005_0004, 32'h0BAD_0BAD, 32'h0000_0077, 3'd2,
          4'h3, 5'h00, 4'd7, 8, 4'hF, 32'h000F_0008, 1'b1, 8, 9, 1'b0);
    wait_done();

    // 4. Response held off for 5 cycles.
    rsp_ready = 1'b0;
    issue(32'h0, 32'h10, 32'h20, 32'h0, 32'h0, 3'd1, 4'h1, 5'h01, 4'd3,
          1, 4'hF, 32'h30, 1'b1, 1, 2, 1'b0);
    t = 0;
    while (!rsp_valid && t < 50) begin
      @(negedge g_clk);
      t++;
    end
    chk("rsp_valid_seen", rsp_valid, 1'b1);
    repeat (5) @(negedge g_clk);
    rsp_ready = 1'b1;
    wait_done();

    // 5. PALU never finishes: watchdog after 64 EXEC cycles, no write.
    issue(32'h0, 32'h1, 32'h2, 32'h3, 32'h4, 3'd2, 4'h3, 5'h00, 4'd9,
          0, 4'hF, 32'h5555_5555, 1'b1, 0, 64, 1'b1);
    wait_done();

    // idone on the very last watchdog cycle wins: partial byte write then response.
    issue(32'h0, 32'h0000_00EE, 32'h1, 32'h0, 32'h0, 3'd1, 4'h1, 5'h02, 4'd10,
          64, 4'b0011, 32'h0000_BEEF, 1'b1, 64, 65, 1'b0);
    wait_done();

    // 6. Reset mid-EXEC of a multiply: nothing written, nothing reported.
    issue(32'h0, 32'h0007_0007, 32'h0006_0006, 32'h0, 32'h0, 3'd2, 4'h3, 5'h00, 4'd4,
          8, 4'hF, 32'h002A_002A, 1'b0, 0, 0, 1'b0);
    @(negedge g_clk);
    #2 g_reset = 1'b1;
    #1 chk_all_zero("async_reset_mid_exec");
    @(negedge g_clk);
    g_reset = 1'b0;
    repeat (12) @(negedge g_clk);
    chk("no_write_after_reset", wq.size(), 0);
    issue(32'h0, 32'h7FFF_FFFF, 32'h1, 32'h0, 32'h0, 3'd1, 4'h1, 5'h01, 4'd1,
          1, 4'hF, 32'h8000_0000, 1'b1, 1, 2, 1'b0);
    wait_done();

    repeat (3) @(negedge g_clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute backstop in case a wait above never completes.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got time %0t", $time);
    $fatal(1, "global timeout");
  end

endmodule
